// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: bus master for a ps2 register slave; turns received bytes into buffered key events
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   busRead/busWrite            one-cycle strobes to the slave
//   busAddress                  0 data, 1 status, 2 config; held until response or abort
//   busDataOut                  config write data (bit0 = ire)
//   busReadValid/busDataIn      slave read response
//   ps2Irq                      slave interrupt (USE_IRQ=1 only)
//   evValid/evData/evRead       event FIFO head {ext, brk, code}, pop strobe
//   overflow                    sticky dropped-event flag
//   parErrCount/timeoutCount    saturating error counters
//   clearErrs                   clears overflow and both counters
module ps2_key_sequencer #(
  parameter int USE_IRQ       = 0,
  parameter int POLL_INTERVAL = 256,
  parameter int TIMEOUT       = 16,
  parameter int DEPTH         = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        busRead,
  output logic        busWrite,
  output logic [1:0]  busAddress,
  output logic [31:0] busDataOut,
  input  logic        busReadValid,
  input  logic [31:0] busDataIn,
  input  logic        ps2Irq,
  output logic        evValid,
  output logic [9:0]  evData,
  input  logic        evRead,
  output logic        overflow,
  output logic [7:0]  parErrCount,
  output logic [7:0]  timeoutCount,
  input  logic        clearErrs
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {CFG, IDLE, RDSTAT, WSTAT, RDDATA, WDATA, DECODE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0] addr_q;
  logic [7:0] byte_q, byte_d;
  logic par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic [9:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic ovf_q;
  logic [7:0] perr_q, tcnt_q;
  logic poll_hit, tmo_hit, waiting, good, prefix, push, pop, full, accept, timeout, par_bad;
  logic unused_bits;
  assign unused_bits = ^busDataIn[31:9];
  assign poll_hit = poll_q == PW'(POLL_INTERVAL - 1);
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign waiting = state_q == WSTAT || state_q == WDATA;
  assign good = ^{par_q, byte_q};
  assign prefix = byte_q == 8'hE0 || byte_q == 8'hF0;
  assign push = state_q == DECODE && good && !prefix;
  assign par_bad = state_q == DECODE && !good;
  assign pop = evRead && evValid;
  assign full = cnt_q == (AW+1)'(DEPTH);
  // a full FIFO still takes the push when the head leaves in the same cycle
  assign accept = push && (!full || pop);
  assign timeout = waiting && !busReadValid && tmo_hit;
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG:     state_d = IDLE;
      IDLE:    if (USE_IRQ != 0 ? ps2Irq : poll_hit) state_d = RDSTAT;
      RDSTAT:  state_d = WSTAT;
      WSTAT:   if (busReadValid) state_d = busDataIn[0] ? RDDATA : IDLE;
               else if (tmo_hit) state_d = IDLE;
      RDDATA:  state_d = WDATA;
      WDATA:   if (busReadValid) state_d = DECODE;
               else if (tmo_hit) state_d = IDLE;
      DECODE:  state_d = IDLE;
      default: state_d = CFG;
    endcase
  end
  // poll counter runs in every state so polls are POLL_INTERVAL apart; it parks at the limit until IDLE consumes it
  assign poll_d = USE_IRQ != 0 ? '0 : (state_q == IDLE && poll_hit) ? '0 : poll_hit ? poll_q : poll_q + PW'(1);
  assign tmo_d = !waiting ? '0 : tmo_hit ? tmo_q : tmo_q + TW'(1);
  assign byte_d = (state_q == WDATA && busReadValid) ? busDataIn[7:0] : byte_q;
  assign par_d = (state_q == WDATA && busReadValid) ? busDataIn[8] : par_q;
  // prefixes accumulate; any other good byte, or any bad byte, clears both
  assign ext_d = state_q != DECODE ? ext_q : good && (byte_q == 8'hE0 || (byte_q == 8'hF0 && ext_q));
  assign brk_d = state_q != DECODE ? brk_q : good && (byte_q == 8'hF0 || (byte_q == 8'hE0 && brk_q));
  assign busWrite = !reset && state_q == CFG;
  assign busRead = !reset && (state_q == RDSTAT || state_q == RDDATA);
  assign busAddress = reset ? 2'd0 : state_q == CFG ? 2'd2 : state_q == RDSTAT ? 2'd1 : state_q == RDDATA ? 2'd0 : addr_q;
  assign busDataOut = busWrite ? {31'd0, USE_IRQ != 0} : 32'd0;
  assign evValid = cnt_q != '0;
  assign evData = mem_q[rp_q];
  assign overflow = ovf_q;
  assign parErrCount = perr_q;
  assign timeoutCount = tcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CFG;
      poll_q <= '0;
      tmo_q <= '0;
      addr_q <= 2'd0;
      byte_q <= 8'd0;
      par_q <= 1'b0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 8'd0;
      tcnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      poll_q <= poll_d;
      tmo_q <= tmo_d;
      addr_q <= busAddress;
      byte_q <= byte_d;
      par_q <= par_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      wp_q <= wp_q + AW'(accept);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
      ovf_q <= clearErrs ? 1'b0 : ovf_q | (push && !accept);
      perr_q <= clearErrs ? 8'd0 : perr_q + 8'(par_bad && perr_q != 8'hFF);
      tcnt_q <= clearErrs ? 8'd0 : tcnt_q + 8'(timeout && tcnt_q != 8'hFF);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q] <= {ext_q, brk_q, byte_q};
  end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: scoreboard bench for ps2_key_sequencer in polled and irq modes
module tb_ps2_key_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst0 = 1, rst1 = 1;
  logic rd0, wr0, rv0 = 0, irq0 = 0, ev_valid0, ev_read0 = 0, ovf0, clr0 = 0;
  logic [1:0] addr0;
  logic [31:0] dout0, din0 = 0;
  logic [9:0] ev_data0;
  logic [7:0] perr0, tcnt0;
  logic rd1, wr1, rv1 = 0, irq1 = 0, ev_valid1, ev_read1 = 0, ovf1, clr1 = 0;
  logic [1:0] addr1;
  logic [31:0] dout1, din1 = 0;
  logic [9:0] ev_data1;
  logic [7:0] perr1, tcnt1;
  ps2_key_sequencer #(.USE_IRQ(0), .POLL_INTERVAL(8), .TIMEOUT(5), .DEPTH(8)) dut0 (
    .clk(clk), .reset(rst0), .busRead(rd0), .busWrite(wr0), .busAddress(addr0), .busDataOut(dout0),
    .busReadValid(rv0), .busDataIn(din0), .ps2Irq(irq0), .evValid(ev_valid0), .evData(ev_data0),
    .evRead(ev_read0), .overflow(ovf0), .parErrCount(perr0), .timeoutCount(tcnt0), .clearErrs(clr0));
  ps2_key_sequencer #(.USE_IRQ(1), .POLL_INTERVAL(8), .TIMEOUT(5), .DEPTH(8)) dut1 (
    .clk(clk), .reset(rst1), .busRead(rd1), .busWrite(wr1), .busAddress(addr1), .busDataOut(dout1),
    .busReadValid(rv1), .busDataIn(din1), .ps2Irq(irq1), .evValid(ev_valid1), .evData(ev_data1),
    .evRead(ev_read1), .overflow(ovf1), .parErrCount(perr1), .timeoutCount(tcnt1), .clearErrs(clr1));
  int checks = 0, errors = 0, ndata = 0, npop = 0;
  logic [9:0] exp_q [$];
  logic [31:0] data_q [$];
  bit mute = 0, drain = 0, sync_req = 0, sync_done = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic logic [31:0] w(input logic [7:0] b, input bit ok);
    return {23'd0, ok ? ~^b : ^b, b};
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_q();
    int t = 0;
    while (data_q.size() != 0 && t < 1000) begin
      step(1);
      t++;
    end
    chk("queue_drained", t < 1000, 1);
    step(24);
  endtask
  // slave model: answers reads two cycles after the strobe, status bit0 = bytes pending
  initial begin
    logic [1:0] vp;
    logic [31:0] dp0, dp1;
    bit isd0, isd1, arm;
    vp = 0; dp0 = 0; dp1 = 0; isd0 = 0; isd1 = 0; arm = 0;
    forever begin
      @(posedge clk);
      #2;
      ev_read0 = drain | arm;
      arm = 0;
      rv0 = vp[1];
      din0 = dp1;
      if (vp[1] && isd1 && sync_req && !sync_done) begin
        arm = 1;
        sync_done = 1;
      end
      vp[1] = vp[0];
      dp1 = dp0;
      isd1 = isd0;
      vp[0] = rd0 && !mute;
      isd0 = addr0 == 2'd0;
      if (rd0 && !mute) begin
        if (addr0 == 2'd1) dp0 = {31'd0, data_q.size() != 0};
        else begin
          ndata++;
          dp0 = data_q.size() != 0 ? data_q.pop_front() : 32'd0;
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (ev_valid0 && ev_read0 && !rst0) begin
        npop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL event_unexpected actual=%0h required=none", ev_data0);
        end else chk("event", ev_data0, exp_q.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nd, p0;
    step(3);
    chk("rst_wr", wr0, 0);
    chk("rst_rd", rd0, 0);
    chk("rst_evvalid", ev_valid0, 0);
    chk("rst_addr", addr0, 0);
    rst0 = 0;
    #1;
    chk("cfg_wr", wr0, 1);
    chk("cfg_addr", addr0, 2);
    chk("cfg_dout", dout0, 0);
    n = 0;
    while (!rd0 && n < 100) begin
      step(1);
      n++;
    end
    chk("poll_gap", n, 8);
    chk("poll_addr", addr0, 1);
    drain = 1;
    data_q = {w(8'h1C, 1), w(8'hF0, 1), w(8'h1C, 1), w(8'hE0, 1), w(8'hF0, 1), w(8'h75, 1)};
    exp_q = {10'h01C, 10'h11C, 10'h375};
    wait_q();
    chk("seq_events_left", exp_q.size(), 0);
    nd = ndata;
    step(32);
    chk("no_data_read", ndata, nd);
    data_q = {w(8'h1C, 0), w(8'h1C, 1), w(8'hE0, 1), w(8'hF0, 0), w(8'h1C, 1)};
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h01C);
    wait_q();
    chk("par_err_count", perr0, 2);
    chk("par_events_left", exp_q.size(), 0);
    mute = 1;
    n = 0;
    while (!rd0 && n < 100) begin
      step(1);
      n++;
    end
    chk("tmo_strobe", rd0, 1);
    step(5);
    chk("tmo_before", tcnt0, 0);
    step(1);
    chk("tmo_after", tcnt0, 1);
    mute = 0;
    n = 0;
    while (!rd0 && n < 100) begin
      step(1);
      n++;
    end
    chk("tmo_repoll", rd0, 1);
    step(8);
    drain = 0;
    for (int i = 1; i <= 9; i++) data_q.push_back(w(8'(i), 1));
    for (int i = 1; i <= 8; i++) exp_q.push_back(10'(i));
    wait_q();
    chk("full_overflow", ovf0, 1);
    chk("full_valid", ev_valid0, 1);
    chk("full_head", ev_data0, 10'h001);
    p0 = npop;
    sync_req = 1;
    data_q.push_back(w(8'h0A, 1));
    exp_q.push_back(10'h00A);
    wait_q();
    chk("sync_popped", sync_done, 1);
    chk("sync_pop_count", npop - p0, 1);
    p0 = npop;
    drain = 1;
    step(30);
    chk("drain_pops", npop - p0, 8);
    chk("drain_empty", ev_valid0, 0);
    chk("drain_events_left", exp_q.size(), 0);
    clr0 = 1;
    step(1);
    clr0 = 0;
    chk("clr_overflow", ovf0, 0);
    chk("clr_parerr", perr0, 0);
    chk("clr_timeout", tcnt0, 0);
    chk("irq_rst_wr", wr1, 0);
    rst1 = 0;
    #1;
    chk("irq_cfg_wr", wr1, 1);
    chk("irq_cfg_addr", addr1, 2);
    chk("irq_cfg_dout", dout1, 1);
    n = 0;
    repeat (6) begin
      step(1);
      if (rd1) n++;
    end
    chk("irq_no_read", n, 0);
    irq1 = 1;
    step(1);
    chk("irq_stat_rd", rd1, 1);
    chk("irq_stat_addr", addr1, 1);
    irq1 = 0;
    step(1);
    chk("irq_wstat_addr", addr1, 1);
    step(1);
    rv1 = 1;
    din1 = 32'd1;
    step(1);
    rv1 = 0;
    chk("irq_data_rd", rd1, 1);
    chk("irq_data_addr", addr1, 0);
    step(1);
    chk("irq_wdata_hold", addr1, 0);
    rst1 = 1;
    step(1);
    rst1 = 0;
    rv1 = 1;
    din1 = w(8'h1C, 1);
    #1;
    chk("irq_reset_cfg", wr1, 1);
    chk("irq_reset_addr", addr1, 2);
    step(1);
    rv1 = 0;
    n = 0;
    repeat (6) begin
      if (rd1) n++;
      step(1);
    end
    chk("stale_no_read", n, 0);
    chk("stale_no_event", ev_valid1, 0);
    chk("stale_parerr", perr1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
